// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Instruction-memory request/response bus between the IF stage and imem.
//   imem_req     master -> slave  fetch request outstanding
//   imem_addr    master -> slave  word-aligned fetch address
//   imem_rvalid  slave -> master  response valid (same cycle as req or later)
//   imem_rdata   slave -> master  instruction word, qualified by imem_rvalid
// -----------------------------------------------------------------------------
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// IF stage: owns the program counter and fetches one 32-bit instruction per
// cycle over the imem req/rvalid handshake, feeding the IF/ID register.
// Handles hazard stalls, branch/jump redirects and variable memory latency;
// a NOP bubble is presented whenever no real instruction is available.
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   synchronous, active-high
//   stall_IF     in   hazard unit: hold current fetch
//   redirect     in   taken branch/jump from EX
//   redirect_pc  in   redirect target (bits [1:0] dropped)
//   imem         if   instruction-memory bus (master side)
//   Inst_out     out  instruction to IF/ID
//   PCF          out  PC of Inst_out / current fetch address
//   inst_valid   out  Inst_out is a real fetched instruction
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall_IF,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    fetch_unit_if.master        imem,
    output logic [31:0]         Inst_out,
    output logic [31:0]         PCF,
    output logic                inst_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] pcf, pcf_n;
    logic        pending_kill, pending_kill_n;
    logic [31:0] pending_pc, pending_pc_n;
    logic [31:0] hold_buf, hold_buf_n;

    logic        req_c;
    logic [31:0] inst_c;
    logic        valid_c;

    logic [31:0] target_pc;
    logic [31:0] pc_plus4;
    logic        unused_target_lsbs;

    // Instructions are word aligned; the low target bits carry no information.
    assign target_pc          = {redirect_pc[31:2], 2'b00};
    assign unused_target_lsbs = ^redirect_pc[1:0];
    assign pc_plus4           = pcf + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            pcf          <= RESET_PC;
            pending_kill <= 1'b0;
            pending_pc   <= 32'h0000_0000;
            hold_buf     <= NOP_INST;
        end else begin
            state        <= state_n;
            pcf          <= pcf_n;
            pending_kill <= pending_kill_n;
            pending_pc   <= pending_pc_n;
            hold_buf     <= hold_buf_n;
        end
    end

    always_comb begin
        state_n        = state;
        pcf_n          = pcf;
        pending_kill_n = pending_kill;
        pending_pc_n   = pending_pc;
        hold_buf_n     = hold_buf;
        req_c          = 1'b0;
        inst_c         = NOP_INST;
        valid_c        = 1'b0;

        unique case (state)
            IDLE: begin
                state_n = FETCH;
            end

            FETCH: begin
                req_c = 1'b1;
                if (!imem.imem_rvalid) begin
                    // Address must stay put until the response lands, so a
                    // redirect seen now is remembered and applied afterwards.
                    if (redirect) begin
                        pending_kill_n = 1'b1;
                        pending_pc_n   = target_pc;
                    end
                end else if (redirect || pending_kill) begin
                    // Wrong-path response: drop it. A same-cycle redirect is
                    // newer than the remembered one and therefore wins.
                    pcf_n          = redirect ? target_pc : pending_pc;
                    pending_kill_n = 1'b0;
                end else if (stall_IF) begin
                    inst_c     = imem.imem_rdata;
                    valid_c    = 1'b1;
                    hold_buf_n = imem.imem_rdata;
                    state_n    = HOLD;
                end else begin
                    inst_c  = imem.imem_rdata;
                    valid_c = 1'b1;
                    pcf_n   = pc_plus4;
                end
            end

            HOLD: begin
                inst_c  = hold_buf;
                valid_c = 1'b1;
                if (redirect) begin
                    inst_c  = NOP_INST;
                    valid_c = 1'b0;
                    pcf_n   = target_pc;
                    state_n = FETCH;
                end else if (!stall_IF) begin
                    pcf_n   = pc_plus4;
                    state_n = FETCH;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Reset masks the outputs immediately, even before the state register
    // has been cleared, so nothing leaks out mid-transaction.
    assign imem.imem_req  = reset ? 1'b0 : req_c;
    assign imem.imem_addr = pcf;
    assign Inst_out       = reset ? NOP_INST : inst_c;
    assign inst_valid     = reset ? 1'b0 : valid_c;
    assign PCF            = pcf;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Randomized bench for fetch_unit. The stimulus process drives reset, stalls,
// redirects and a variable-latency instruction memory, and keeps a queue of
// the PCs the program flow should deliver next. A separate monitor checks
// every presented instruction against that queue and the memory contents.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam int          NCYC     = 3000;
    localparam int          TAILCYC  = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_IF;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] Inst_out;
    logic [31:0] PCF;
    logic        inst_valid;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall_IF    (stall_IF),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (bus.master),
        .Inst_out    (Inst_out),
        .PCF         (PCF),
        .inst_valid  (inst_valid)
    );

    always #5 clk = ~clk;

    // Instruction memory contents as a pure function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    logic [31:0] exp_q[$];
    bit          tail;
    bit          finish_req;

    // ---------------- stimulus + memory + flow model ----------------
    initial begin
        int          rel;
        bit          outst;
        int          lat;
        int          stall_pct;
        logic [31:0] nxt;
        reset       = 1'b1;
        stall_IF    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        tail        = 1'b0;
        finish_req  = 1'b0;
        rel   = 0;
        outst = 1'b0;
        lat   = 0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            tail  = (cyc >= NCYC - TAILCYC);
            reset = (cyc < 2) ||
                    (!tail && (cyc % 700 >= 350) && (cyc % 700 < 352)) ||
                    (!tail && $urandom_range(0, 249) == 0);
            if (reset) rel = 0;
            else       rel++;

            // Alternate between light and heavy stall phases so HOLD is visited often.
            stall_pct = ((cyc / 100) % 2 == 1) ? 60 : 20;
            stall_IF  = !tail && ($urandom_range(0, 99) < stall_pct);
            redirect  = !reset && !tail && (rel >= 2) && ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 7) == 0)
                redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else
                redirect_pc = $urandom & 32'h0000_0FFF;

            // Program flow: after reset or a redirect, everything not yet
            // delivered is discarded and fetching continues from the new PC.
            if (reset) begin
                exp_q.delete();
                exp_q.push_back(RESET_PC);
            end else if (redirect) begin
                exp_q.delete();
                exp_q.push_back(redirect_pc & 32'hFFFF_FFFC);
            end
            while (exp_q.size() < 4) begin
                nxt = exp_q[$] + 32'd4;
                exp_q.push_back(nxt);
            end

            // Memory: fresh latency of 0..3 cycles per request.
            if (reset) begin
                outst = 1'b0;
                bus.imem_rvalid = 1'b0;
            end else if (bus.imem_req) begin
                if (!outst) begin
                    outst = 1'b1;
                    lat   = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
                end
                if (lat == 0) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = mem_word(bus.imem_addr);
                    outst = 1'b0;
                end else begin
                    bus.imem_rvalid = 1'b0;
                    bus.imem_rdata  = $urandom;
                    lat--;
                end
            end else begin
                bus.imem_rvalid = 1'b0;
            end
        end
        finish_req = 1'b1;
    end

    // ---------------- monitor / scoreboard ----------------
    int          vectors = 0;
    int          miscompares = 0;
    int          since_rel = 0;
    int          tail_cons = 0;
    bit          rst_seen = 1'b0;
    bit          prev_wait = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, expv);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        if (finish_req) begin
            chk("tail_progress", 32'(tail_cons >= 5), 32'd1);
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end else if (reset) begin
            chk("rst_req",   32'(bus.imem_req), 32'd0);
            chk("rst_inst",  Inst_out, NOP);
            chk("rst_valid", 32'(inst_valid), 32'd0);
            if (rst_seen) chk("rst_pcf", PCF, RESET_PC);
            rst_seen  = 1'b1;
            since_rel = 0;
            prev_wait = 1'b0;
        end else begin
            rst_seen = 1'b0;
            since_rel++;
            if (since_rel == 1) chk("idle_req", 32'(bus.imem_req), 32'd0);
            if (since_rel == 2) begin
                chk("first_req",  32'(bus.imem_req), 32'd1);
                chk("first_addr", bus.imem_addr, RESET_PC);
            end
            chk("pc_align", 32'(PCF[1:0]), 32'd0);
            if (bus.imem_req) chk("addr_eq_pcf", bus.imem_addr, PCF);
            if (prev_wait) begin
                chk("req_held",    32'(bus.imem_req), 32'd1);
                chk("addr_stable", bus.imem_addr, prev_addr);
            end
            prev_wait = bus.imem_req && !bus.imem_rvalid;
            prev_addr = bus.imem_addr;

            if (!inst_valid) chk("bubble", Inst_out, NOP);
            else             chk("inst_data", Inst_out, mem_word(PCF));

            // An instruction is taken by IF/ID when it is valid and not stalled.
            if (inst_valid && !stall_IF) begin
                if (exp_q.size() == 0) begin
                    chk("exp_empty", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("flow_pc", PCF, e);
                end
                if (tail) tail_cons++;
            end
        end
    end
endmodule
